// File: rtl/redmule_castout_ctrl_pkg.sv
// Shared types and defaults for the output cast controller and its result FIFO.
package redmule_castout_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } castout_state_e;

  // Cast datapath latency follows whether the cast unit pipeline register is enabled.
  localparam bit          CAST_PIPE          = 1'b0;
  localparam int unsigned CASTOUT_LAT        = CAST_PIPE ? 1 : 0;
  localparam int unsigned CASTOUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/redmule_castout_ctrl_fifo.sv
// Result FIFO for the cast-out path: wrap-bit pointers, same-cycle push/pop at any occupancy.
module redmule_castout_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wptr_q, rptr_q;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (count_o == '0);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  // The upstream credit check must make an unmatched push into a full FIFO impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i)
      assert (!(push_i && full_o && !pop_i)) else $error("castout fifo overflow");
  end

endmodule

// File: rtl/redmule_castout_ctrl.sv
// Job sequencer around the output cast unit: latches job config, tracks in-flight words
// through the fixed-latency cast path and buffers results behind a credit-protected FIFO.
module redmule_castout_ctrl #(
  parameter int unsigned DATA_W     = redmule_castout_ctrl_pkg::DATA_W,
  parameter int unsigned CAST_LAT   = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic                                 cast_en_i,
  input  redmule_castout_ctrl_pkg::fp_format_e dst_fmt_i,
  input  logic [CNT_W-1:0]                     num_words_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [DATA_W-1:0]                    in_data_i,
  output logic                                 cast_o,
  output redmule_castout_ctrl_pkg::fp_format_e dst_fmt_o,
  output logic [DATA_W-1:0]                    cast_src_o,
  input  logic [DATA_W-1:0]                    cast_res_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [DATA_W-1:0]                    out_data_o,
  output logic                                 busy_o,
  output logic                                 done_o
);
  import redmule_castout_ctrl_pkg::*;

  localparam int unsigned FAW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FAW:0] CNT_ONE = (FAW+1)'(1);

  castout_state_e   state_q;
  logic             cast_q;
  fp_format_e       fmt_q;
  logic [CNT_W-1:0] words_q, cnt_q;

  logic             accept, push, pop, drained;
  logic             fifo_full, fifo_empty;
  logic [FAW:0]     fifo_cnt;
  logic [1:0]       inflight;

  // Credits count both buffered results and words still inside the cast path.
  assign in_ready_o  = (state_q == RUN) && ((32'(inflight) + 32'(fifo_cnt)) < FIFO_DEPTH);
  assign accept      = in_valid_i && in_ready_o;
  assign cast_src_o  = in_data_i;
  assign cast_o      = cast_q;
  assign dst_fmt_o   = fmt_q;
  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;
  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);

  generate
    if (CAST_LAT == 0) begin : g_comb
      assign push     = accept;
      assign inflight = 2'd0;
    end else begin : g_pipe
      logic [CAST_LAT-1:0] vpipe_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        vpipe_q <= '0;
        else if (clear_i) vpipe_q <= '0;
        else              vpipe_q <= CAST_LAT'({vpipe_q, accept});
      end
      assign push     = vpipe_q[CAST_LAT-1];
      assign inflight = 2'($countones(vpipe_q));
    end
  endgenerate

  // Leave DRAIN in the cycle the last result is handed downstream.
  assign drained = (inflight == 2'd0) && (fifo_empty || ((fifo_cnt == CNT_ONE) && pop));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cast_q  <= 1'b0;
      fmt_q   <= FP32;
      words_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          cast_q  <= cast_en_i;
          fmt_q   <= dst_fmt_i;
          words_q <= num_words_i;
          cnt_q   <= '0;
          state_q <= (num_words_i == '0) ? DONE : RUN;
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == words_q - 1'b1) state_q <= DRAIN;
        end
        DRAIN:   if (drained) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  redmule_castout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (cast_res_i),
    .pop_i   (pop),
    .data_o  (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: doc/redmule_castout_ctrl.md
Name: redmule_castout_ctrl

Overview:
Sequencing and flow-control wrapper around the output cast datapath. Accepts a job of N result words from the engine, latches the cast configuration (enable, destination format) for the whole job, and drives each word through the cast unit. The cast unit has a fixed latency of CAST_LAT cycles and no backpressure of its own. The block absorbs downstream stalls with a credit-protected result FIFO and signals job completion to the scheduler. It sits between the engine output buffer and the store streamer.

Parameters:
DATA_W, redmule_pkg::DATA_W, width of one data word.
CAST_LAT, 0, cast datapath latency in cycles (0 = combinational, 1 = Pipe enabled); legal range 0..2.
FIFO_DEPTH, 4, result FIFO entries; must be >= CAST_LAT+1 and a power of two.
CNT_W, 16, width of the job word counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
clear_i  in  1  synchronous soft clear; aborts the job and flushes all state
start_i  in  1  job start pulse; sampled only in IDLE
cast_en_i  in  1  job config: 1 = cast, 0 = bypass
dst_fmt_i  in  fpnew_pkg::fp_format_e  job config: destination format
num_words_i  in  CNT_W  job config: number of words in the job
in_valid_i  in  1  engine word valid
in_ready_o  out  1  engine word accepted when valid & ready
in_data_i  in  DATA_W  engine word
cast_o  out  1  latched cast enable to the datapath
dst_fmt_o  out  fp_format_e  latched destination format to the datapath
cast_src_o  out  DATA_W  word presented to the datapath (= in_data_i)
cast_res_i  in  DATA_W  datapath result, valid CAST_LAT cycles after the word was accepted
out_valid_o  out  1  result word valid (FIFO not empty)
out_ready_i  in  1  downstream ready
out_data_o  out  DATA_W  FIFO head
busy_o  out  1  high in RUN and DRAIN
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; dst_fmt_o = '0 (FP32); FSM = IDLE; FIFO empty; counters 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start_i when num_words_i != 0. This latches cast_en_i, dst_fmt_i and num_words_i, and clears the accepted-word count.
- IDLE -> DONE on start_i when num_words_i == 0.
- RUN -> DRAIN in the cycle the last word (count == num_words-1) is accepted.
- DRAIN -> DONE when in-flight == 0 and the FIFO is empty.
- DONE -> IDLE unconditionally after one cycle. done_o is 1 only in DONE.
- start_i outside IDLE is ignored. cast_o and dst_fmt_o stay constant from RUN entry until the next start.
- in_ready_o = (state == RUN) & (inflight + fifo_count < FIFO_DEPTH). It is combinational from registered state only and never depends on in_valid_i.
- Valid pipe:
  - A CAST_LAT-deep shift register tracks accepted words.
  - The FIFO pushes cast_res_i when the tail bit is set. For CAST_LAT = 0, the push happens in the accept cycle.
  - inflight = popcount of the shift register.
- FIFO:
  - Pop on out_valid_o & out_ready_i.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - The credit rule guarantees a push never arrives at a full FIFO; the implementation asserts this.
  - Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for the full/empty distinction.
- Output ordering equals input ordering; no word is dropped or duplicated.
- clear_i has priority over all other events in the same cycle. It forces IDLE, empties the FIFO and valid pipe, and zeroes counters. It does not pulse done_o. Latched config is retained.
- rst_i asserted mid-job has the same effect as clear_i, asynchronously, and also resets the config registers.
- The counter does not wrap: a job of 2^CNT_W-1 words completes normally.

Decomposition:
- redmule_pkg gains:
  - castout_state_e (IDLE/RUN/DRAIN/DONE);
  - CASTOUT_LAT constant derived from the Pipe setting;
  - CASTOUT_FIFO_DEPTH default.
- One sub-module, redmule_castout_fifo: parameterised depth/width FIFO with push, pop, full, empty and count.
- The controller instantiates the FIFO and is instantiated beside the cast unit in the engine's output path.

Test Plan:
- Bypass job: cast_en=0, num_words=3, CAST_LAT=0, out_ready=1, words A,B,C back-to-back -> out A,B,C on consecutive cycles; cast_o=0; done_o pulses once, two cycles after the last accept.
- Cast job: cast_en=1, dst_fmt=FP16, CAST_LAT=1, num_words=8, model datapath = identity+1 -> 8 outputs equal input+1 in order; dst_fmt_o=FP16 throughout; busy_o high from start+1 until DONE.
- Backpressure: FIFO_DEPTH=4, CAST_LAT=2, out_ready=0, in_valid held high -> exactly 4 words accepted, then in_ready_o=0. Raise out_ready -> remaining words flow, no overflow assertion, order preserved.
- Zero-length job: start with num_words=0 -> done_o pulses in the next cycle; in_ready_o never asserts.
- Abort: clear_i in RUN with 2 words in flight and 3 in the FIFO -> next cycle out_valid_o=0, busy_o=0, no done_o; a new start then completes correctly.
- Simultaneous: FIFO full, pop and pipe-tail push in the same cycle -> count unchanged, data correct. Also a start_i pulse during RUN -> ignored; config unchanged.
